if_fetch_unit: RTL

- PC generator and instruction-bus master for the IF stage.
- Holds the architectural fetch PC and issues one outstanding instruction-bus read at a time.
- Delivers fetched words to the IF/ID register.
- Consumes stall, flush and new_pc from the pipeline controller, and produces the controller's IF stall request while a fetch is in flight.
- Discards responses made stale by a redirect.

---
 rtl/if_fetch_unit_pkg.sv | 25 ++
 rtl/if_fetch_unit_next_pc.sv | 22 ++
 rtl/if_fetch_unit.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared defines and package for the IF fetch unit: bus width, reset/stop levels,
// NOP word, FSM state encoding and stall-vector bit positions.
`ifndef IF_FETCH_UNIT_DEFINES
`define IF_FETCH_UNIT_DEFINES
`define RegBus    31:0
`define ZeroWord  32'h0000_0000
`define RstEnable 1'b1
`define Stop      1'b1
`define NopInst   32'h0000_0013
`endif

package if_fetch_unit_pkg;
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_REQ     = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_DISCARD = 3'd4;

    localparam int STALL_PC   = 0;
    localparam int STALL_IFID = 1;
    localparam int STALL_ID   = 2;
    localparam int STALL_EX   = 3;
    localparam int STALL_MEM  = 4;
    localparam int STALL_WB   = 5;
endpackage

// File: rtl/if_fetch_unit_next_pc.sv
// Redirect priority (flush over branch), pending-redirect select and sequential PC.
module if_next_pc (
    input  logic [`RegBus] fetch_pc,
    input  logic           flush,
    input  logic [`RegBus] new_pc,
    input  logic           branch_flag,
    input  logic [`RegBus] branch_target,
    input  logic           pending_vld,
    input  logic [`RegBus] pending_pc,
    output logic           redir,
    output logic [`RegBus] redir_pc,
    output logic           tgt_vld,
    output logic [`RegBus] tgt_pc,
    output logic [`RegBus] seq_pc
);
    assign redir    = flush | branch_flag;
    assign redir_pc = flush ? new_pc : branch_target;
    // A redirect arriving this cycle supersedes one already latched.
    assign tgt_vld  = redir | pending_vld;
    assign tgt_pc   = redir ? redir_pc : pending_pc;
    assign seq_pc   = fetch_pc + 32'd4;
endmodule

// File: rtl/if_fetch_unit.sv
// IF-stage PC generator and single-outstanding instruction-bus master.
// Optional IFETCH_MISALIGN_CHK_EN: misaligned redirect targets are reported instead of fetched.
//
//   state     | meaning
//   S_IDLE    | after reset (or parked on misaligned target until flush)
//   S_REQ     | ibus_req_o high at fetch_pc, waiting for gnt
//   S_WAIT    | granted, waiting for rvalid to deliver
//   S_HOLD    | delivered word re-presented while IF/ID is stalled
//   S_DISCARD | granted fetch made stale by a redirect; drop its rvalid
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = `NopInst
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [5:0]     stall_i,
    input  logic           flush_i,
    input  logic [`RegBus] new_pc_i,
    input  logic           branch_flag_i,
    input  logic [`RegBus] branch_target_i,
    output logic           ibus_req_o,
    output logic [`RegBus] ibus_addr_o,
    input  logic           ibus_gnt_i,
    input  logic           ibus_rvalid_i,
    input  logic [`RegBus] ibus_rdata_i,
    output logic [`RegBus] if_pc_o,
    output logic [`RegBus] if_inst_o,
    output logic           if_valid_o,
`ifdef IFETCH_MISALIGN_CHK_EN
    output logic           if_misalign_o,
`endif
    output logic           stallreq_o
);
    logic [2:0]     state;
    logic [`RegBus] fetch_pc;
    logic [`RegBus] pending_pc;
    logic           pending_vld;
    logic           pc_adv;
    logic           redir;
    logic [`RegBus] redir_pc;
    logic           tgt_vld;
    logic [`RegBus] tgt_pc;
    logic [`RegBus] seq_pc;
    logic           busy;
    logic           unused_stall;

    if_next_pc u_next_pc (
        .fetch_pc      (fetch_pc),
        .flush         (flush_i),
        .new_pc        (new_pc_i),
        .branch_flag   (branch_flag_i),
        .branch_target (branch_target_i),
        .pending_vld   (pending_vld),
        .pending_pc    (pending_pc),
        .redir         (redir),
        .redir_pc      (redir_pc),
        .tgt_vld       (tgt_vld),
        .tgt_pc        (tgt_pc),
        .seq_pc        (seq_pc)
    );

    assign unused_stall = ^{stall_i[STALL_ID], stall_i[STALL_EX],
                            stall_i[STALL_MEM], stall_i[STALL_WB]};

`ifdef IFETCH_MISALIGN_CHK_EN
    logic addr_bad;
    logic halted;
    logic misalign_q;
    assign addr_bad      = (fetch_pc[1:0] != 2'b00);
    assign ibus_req_o    = (state == S_REQ) && !addr_bad;
    assign ibus_addr_o   = fetch_pc;
    assign if_misalign_o = misalign_q;
`else
    assign ibus_req_o    = (state == S_REQ);
    assign ibus_addr_o   = {fetch_pc[31:2], 2'b00};
`endif

    assign busy       = (state == S_REQ) || (state == S_WAIT) || (state == S_DISCARD);
    assign stallreq_o = (busy && !((state == S_WAIT) && ibus_rvalid_i && !tgt_vld)) ? `Stop : !`Stop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst == `RstEnable) begin
            state       <= S_IDLE;
            fetch_pc    <= RESET_PC;
            pending_pc  <= RESET_PC;
            pending_vld <= 1'b0;
            pc_adv      <= 1'b0;
            if_pc_o     <= `ZeroWord;
            if_inst_o   <= NOP_INST;
            if_valid_o  <= 1'b0;
`ifdef IFETCH_MISALIGN_CHK_EN
            halted      <= 1'b0;
            misalign_q  <= 1'b0;
`endif
        end else begin
            if_valid_o <= 1'b0;
            if_inst_o  <= NOP_INST;
`ifdef IFETCH_MISALIGN_CHK_EN
            misalign_q <= 1'b0;
`endif
            if (redir) begin
                pending_pc  <= redir_pc;
                pending_vld <= 1'b1;
            end
            case (state)
                S_IDLE: begin
`ifdef IFETCH_MISALIGN_CHK_EN
                    if (halted) begin
                        if (flush_i) begin
                            halted      <= 1'b0;
                            fetch_pc    <= new_pc_i;
                            pending_vld <= 1'b0;
                            state       <= S_REQ;
                        end
                    end else
`endif
                    begin
                        state <= S_REQ;
                        if (tgt_vld) begin
                            fetch_pc    <= tgt_pc;
                            pending_vld <= 1'b0;
                        end
                    end
                end
                S_REQ: begin
`ifdef IFETCH_MISALIGN_CHK_EN
                    if (addr_bad) begin
                        if_valid_o  <= 1'b1;
                        if_pc_o     <= fetch_pc;
                        misalign_q  <= 1'b1;
                        halted      <= 1'b1;
                        pending_vld <= 1'b0;
                        state       <= S_IDLE;
                    end else
`endif
                    if (ibus_gnt_i) begin
                        state <= tgt_vld ? S_DISCARD : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ibus_rvalid_i) begin
                        if (tgt_vld) begin
                            fetch_pc    <= tgt_pc;
                            pending_vld <= 1'b0;
                            state       <= S_REQ;
                        end else begin
                            if_valid_o <= 1'b1;
                            if_pc_o    <= fetch_pc;
                            if_inst_o  <= ibus_rdata_i;
                            pc_adv     <= !stall_i[STALL_PC];
                            if (!stall_i[STALL_PC]) fetch_pc <= seq_pc;
                            state <= stall_i[STALL_IFID] ? S_HOLD : S_REQ;
                        end
                    end else if (tgt_vld) begin
                        state <= S_DISCARD;
                    end
                end
                S_HOLD: begin
                    if (tgt_vld) begin
                        fetch_pc    <= tgt_pc;
                        pending_vld <= 1'b0;
                        state       <= S_REQ;
                    end else begin
                        // PC hold may release before the IF/ID hold; advance exactly once.
                        if (!pc_adv && !stall_i[STALL_PC]) begin
                            fetch_pc <= seq_pc;
                            pc_adv   <= 1'b1;
                        end
                        if (stall_i[STALL_IFID]) begin
                            if_valid_o <= 1'b1;
                            if_inst_o  <= if_inst_o;
                        end else begin
                            state <= S_REQ;
                        end
                    end
                end
                S_DISCARD: begin
                    if (ibus_rvalid_i) begin
                        fetch_pc    <= tgt_pc;
                        pending_vld <= 1'b0;
                        state       <= S_REQ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
